output_port_fifo: RTL and testbench

OUTPUT_PORT_FIFO -- requirements
Module: output_port_fifo

---
 rtl/output_port_fifo.sv | 100 ++++++++++
 tb/tb_output_port_fifo.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/output_port_fifo.sv
// output_port_fifo
//   First-word-fall-through FIFO that buffers CPU output words for a host.
//   The CPU writes with a valid/ready handshake. A word offered while the
//   FIFO is full is dropped, and the sticky overflow flag records the drop.
//
// Ports
//   clk       : single clock, rising-edge active
//   reset     : asynchronous, active-high; clears pointers, count and flags
//   wr_valid  : CPU offers wr_data
//   wr_data   : CPU output word (WIDTH bits)
//   wr_ready  : FIFO not full
//   rd_valid  : FIFO not empty, rd_data holds the head entry
//   rd_data   : head entry, or 0 when empty
//   rd_ready  : host accepts the head entry
//   count     : occupancy, 0..DEPTH
//   overflow  : sticky, a word was dropped because the FIFO was full
//   clr_ovf   : synchronous clear of overflow (a drop in the same cycle wins)
module output_port_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_valid,
   input  logic [WIDTH-1:0]           wr_data,
   output logic                       wr_ready,
   output logic                       rd_valid,
   output logic [WIDTH-1:0]           rd_data,
   input  logic                       rd_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   input  logic                       clr_ovf
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          overflow_q, overflow_d;

   logic push, pop, drop;

   // Handshake flags come only from registered occupancy.
   assign wr_ready = (count_q != FULL_CNT);
   assign rd_valid = (count_q != '0);

   assign push = wr_valid & wr_ready;
   assign pop  = rd_valid & rd_ready;
   assign drop = wr_valid & ~wr_ready;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      // DEPTH is a power of two, so plain increments wrap DEPTH-1 -> 0.
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // A drop in the same cycle as clr_ovf keeps the flag set.
      if (drop)         overflow_d = 1'b1;
      else if (clr_ovf) overflow_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage holds no reset; validity is tracked by count and pointers alone.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_output_port_fifo.sv
module tb_output_port_fifo;

   localparam int WIDTH = 3;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic             clk = 1'b0;
   logic             reset;
   logic             wr_valid;
   logic [WIDTH-1:0] wr_data;
   logic             wr_ready;
   logic             rd_valid;
   logic [WIDTH-1:0] rd_data;
   logic             rd_ready;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             clr_ovf;

   output_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .rd_ready (rd_ready),
      .count    (count),
      .overflow (overflow),
      .clr_ovf  (clr_ovf)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: an ordered queue of stored words plus the sticky flag.
   logic [WIDTH-1:0] model_q [$];
   logic             m_ovf;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] head_exp();
      if (model_q.size() == 0) return 32'd0;
      return 32'(model_q[0]);
   endfunction

   task automatic check_all(input string tag);
      check({tag, "_count"},    32'(count),    32'(model_q.size()));
      check({tag, "_rd_valid"}, 32'(rd_valid), 32'(model_q.size() != 0));
      check({tag, "_wr_ready"}, 32'(wr_ready), 32'(model_q.size() != DEPTH));
      check({tag, "_rd_data"},  32'(rd_data),  head_exp());
      check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
   endtask

   // One clock cycle: drive inputs, confirm flags do not follow the inputs
   // combinationally, take the edge, update the model, compare at edge+1.
   task automatic cycle(input logic wv, input logic [WIDTH-1:0] wd,
                        input logic rr, input logic co, input string tag);
      bit full, do_push, do_pop, do_drop;
      wr_valid = wv; wr_data = wd; rd_ready = rr; clr_ovf = co;
      #1;
      check({tag, "_pre_wr_ready"}, 32'(wr_ready), 32'(model_q.size() != DEPTH));
      check({tag, "_pre_rd_valid"}, 32'(rd_valid), 32'(model_q.size() != 0));
      full    = (model_q.size() == DEPTH);
      do_push = wv && !full;
      do_drop = wv && full;
      do_pop  = rr && (model_q.size() != 0);
      @(posedge clk);
      #1;
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(wd);
      if (do_drop)  m_ovf = 1'b1;
      else if (co)  m_ovf = 1'b0;
      check_all(tag);
   endtask

   // Assert reset between edges and confirm it takes effect with no edge.
   task automatic async_reset(input string tag);
      wr_valid = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
      #2 reset = 1'b1;
      #1;
      model_q.delete();
      m_ovf = 1'b0;
      check_all(tag);
      @(posedge clk);
      #3 reset = 1'b0;
   endtask

   task automatic expect_reads(input logic [WIDTH-1:0] v0, input logic [WIDTH-1:0] v1,
                               input logic [WIDTH-1:0] v2, input logic [WIDTH-1:0] v3,
                               input int n, input string tag);
      logic [WIDTH-1:0] exp_vals [4];
      exp_vals[0] = v0; exp_vals[1] = v1; exp_vals[2] = v2; exp_vals[3] = v3;
      for (int i = 0; i < n; i++) begin
         check({tag, "_seq"}, 32'(rd_data), 32'(exp_vals[i]));
         cycle(1'b0, '0, 1'b1, 1'b0, tag);
      end
   endtask

   initial begin
      reset = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0; clr_ovf = 1'b0;
      m_ovf = 1'b0;
      #2;
      check_all("reset");
      @(posedge clk);
      #3 reset = 1'b0;

      // Three pushes, no reads
      cycle(1'b1, 3'd5, 1'b0, 1'b0, "p5");
      cycle(1'b1, 3'd2, 1'b0, 1'b0, "p2");
      cycle(1'b1, 3'd7, 1'b0, 1'b0, "p7");
      check("r28_count", 32'(count), 32'd3);
      check("r28_head",  32'(rd_data), 32'd5);
      check("r28_ovf",   32'(overflow), 32'd0);

      // Drain them in order
      expect_reads(3'd5, 3'd2, 3'd7, 3'd0, 3, "r29");
      check("r29_empty_data", 32'(rd_data), 32'd0);
      check("r29_empty_cnt",  32'(count), 32'd0);

      // Read while empty is ignored
      cycle(1'b0, '0, 1'b1, 1'b0, "empty_rd");

      // Fill, then an overflow drop
      cycle(1'b1, 3'd1, 1'b0, 1'b0, "f1");
      cycle(1'b1, 3'd2, 1'b0, 1'b0, "f2");
      cycle(1'b1, 3'd3, 1'b0, 1'b0, "f3");
      cycle(1'b1, 3'd4, 1'b0, 1'b0, "f4");
      check("r30_full", 32'(wr_ready), 32'd0);
      cycle(1'b1, 3'd6, 1'b0, 1'b0, "drop6");
      check("r30_ovf", 32'(overflow), 32'd1);
      check("r30_cnt", 32'(count), 32'd4);

      // Drop has priority over clear, then clear alone
      cycle(1'b1, 3'd5, 1'b0, 1'b1, "r31a");
      check("r31_keep", 32'(overflow), 32'd1);
      cycle(1'b0, '0, 1'b0, 1'b1, "r31b");
      check("r31_clr", 32'(overflow), 32'd0);

      // Full with read and write: pop only, overflow set
      cycle(1'b1, 3'd7, 1'b1, 1'b0, "r20");
      check("r20_cnt", 32'(count), 32'd3);
      check("r20_ovf", 32'(overflow), 32'd1);
      expect_reads(3'd2, 3'd3, 3'd4, 3'd0, 3, "r30rd");
      cycle(1'b0, '0, 1'b0, 1'b1, "clr");

      // Count held at 2 through simultaneous push/pop with pointer wrap
      cycle(1'b1, 3'd3, 1'b0, 1'b0, "s0");
      cycle(1'b1, 3'd1, 1'b0, 1'b0, "s1");
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 3'(i + 2), 1'b1, 1'b0, "r32");
         check("r32_cnt", 32'(count), 32'd2);
      end
      expect_reads(3'd6, 3'd7, 3'd0, 3'd0, 2, "r32rd");

      // Async reset with three stored words
      cycle(1'b1, 3'd1, 1'b0, 1'b0, "a1");
      cycle(1'b1, 3'd2, 1'b0, 1'b0, "a2");
      cycle(1'b1, 3'd3, 1'b0, 1'b0, "a3");
      async_reset("r33_rst");
      check("r33_cnt", 32'(count), 32'd0);
      cycle(1'b1, 3'd4, 1'b0, 1'b0, "r33_push");
      check("r33_head", 32'(rd_data), 32'd4);

      // Randomized traffic with shifting write/read bias
      for (int i = 0; i < 600; i++) begin
         int unsigned wbias, rbias;
         wbias = ((i / 50) % 2 == 0) ? 80 : 30;
         rbias = ((i / 50) % 2 == 0) ? 30 : 80;
         if ($urandom_range(0, 199) == 0)
            async_reset("rnd_rst");
         else
            cycle($urandom_range(0, 99) < wbias, WIDTH'($urandom),
                  $urandom_range(0, 99) < rbias, $urandom_range(0, 9) == 0, "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
